dcdl_lock_ctrl: RTL and testbench

//  Lock-acquisition and tracking controller for the FMDLL delay line.
//  - Acquisition: a binary search (SAR) over the DCDL coarse code.
//  - Tracking: +/-1 steps driven by phase-detector decisions.
//  - Drives the DCDL code word and the clock-path select, so injection
//    (clk_ext) and recirculation (clk_out) are sequenced by one FSM.
//  - Sits between the phase detector and the DCDL/PTC code inputs.

---
 rtl/fmdll_pkg.sv | 29 ++
 rtl/dcdl_code_stepper.sv | 83 ++++++++
 rtl/dcdl_lock_ctrl.sv | 153 +++++++++++++++
 tb/tb_dcdl_lock_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fmdll_pkg.sv
// rtl/fmdll_pkg.sv - shared FMDLL constants, FSM encoding and clock-path select helpers
package fmdll_pkg;

  localparam int DEF_CODE_W     = 10;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_LOCK_CNT   = 8;
  localparam int DEF_UNLOCK_CNT = 4;

  localparam logic [1:0] SEL_GATE   = 2'b10;
  localparam logic [1:0] SEL_INJECT = 2'b01;
  localparam logic [1:0] SEL_RECIRC = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_TRACK,
    ST_LOCKED
  } state_t;

  function automatic logic [1:0] sel_of(state_t s);
    case (s)
      ST_IDLE:   return SEL_GATE;
      ST_LOCKED: return SEL_RECIRC;
      default:   return SEL_INJECT;
    endcase
  endfunction

endpackage

// File: rtl/dcdl_code_stepper.sv
// rtl/dcdl_code_stepper.sv - saturating DCDL code register with direction history and saturation flag
module dcdl_code_stepper #(
  parameter int CODE_W = 10,
  parameter int CNT_W  = 4
) (
  input  logic              clk_ext,
  input  logic              rst_n,
  input  logic              i_restart,
  input  logic              i_load,
  input  logic [CODE_W-1:0] i_load_val,
  input  logic              i_step,
  input  logic              i_up,
  input  logic              i_clr_cnt,
  output logic [CODE_W-1:0] o_code,
  output logic              o_reversal,
  output logic [CNT_W-1:0]  o_rev_cnt,
  output logic [CNT_W-1:0]  o_same_cnt,
  output logic              o_sat
);

  logic [CODE_W-1:0] r_code;
  logic              r_has_dir;
  logic              r_last_up;
  logic [CNT_W-1:0]  r_rev_cnt;
  logic [CNT_W-1:0]  r_same_cnt;
  logic              r_sat;
  logic              w_at_max;
  logic              w_at_min;
  logic              w_clip;

  assign w_at_max   = (r_code == {CODE_W{1'b1}});
  assign w_at_min   = (r_code == '0);
  assign w_clip     = (i_up && w_at_max) || (!i_up && w_at_min);
  assign o_reversal = r_has_dir && (i_up != r_last_up);

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      r_code     <= '0;
      r_has_dir  <= 1'b0;
      r_last_up  <= 1'b0;
      r_rev_cnt  <= '0;
      r_same_cnt <= '0;
      r_sat      <= 1'b0;
    end else begin
      if (i_load) begin
        r_code <= i_load_val;
      end else if (i_step && !w_clip) begin
        r_code <= i_up ? r_code + CODE_W'(1) : r_code - CODE_W'(1);
      end
      if (i_restart) begin
        r_has_dir  <= 1'b0;
        r_last_up  <= 1'b0;
        r_rev_cnt  <= '0;
        r_same_cnt <= '0;
        r_sat      <= 1'b0;
      end else begin
        if (i_step) begin
          r_has_dir <= 1'b1;
          r_last_up <= i_up;
          if (w_clip) r_sat <= 1'b1;
          // counters saturate so a long LOCKED stay cannot wrap them
          if (o_reversal) begin
            r_rev_cnt  <= (&r_rev_cnt) ? r_rev_cnt : r_rev_cnt + CNT_W'(1);
            r_same_cnt <= '0;
          end else begin
            r_rev_cnt  <= '0;
            r_same_cnt <= (&r_same_cnt) ? r_same_cnt : r_same_cnt + CNT_W'(1);
          end
        end
        if (i_clr_cnt) begin
          r_rev_cnt  <= '0;
          r_same_cnt <= '0;
        end
      end
    end
  end

  assign o_code     = r_code;
  assign o_rev_cnt  = r_rev_cnt;
  assign o_same_cnt = r_same_cnt;
  assign o_sat      = r_sat;

endmodule

// File: rtl/dcdl_lock_ctrl.sv
// rtl/dcdl_lock_ctrl.sv - FMDLL lock controller: SAR acquisition, +/-1 tracking, clock-path sequencing
module dcdl_lock_ctrl
  import fmdll_pkg::*;
#(
  parameter int CODE_W     = DEF_CODE_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT
) (
  input  logic              clk_ext,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pd_valid,
  input  logic              pd_lead,
  output logic [CODE_W-1:0] code,
  output logic [1:0]        sel,
  output logic              locked,
  output logic              busy,
  output logic              range_err
);

  localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BLK_W   = $clog2(SETTLE_CYC + 1);
  localparam int IDX_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [BLK_W-1:0]  r_blank;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [1:0]        r_sel;
  logic              r_locked;
  logic              r_busy;

  logic              w_settled;
  logic              w_take;
  logic              w_restart;
  logic              w_load;
  logic [CODE_W-1:0] w_load_val;
  logic              w_step;
  logic              w_clr_cnt;
  logic              w_blank_clr;
  logic              w_reversal;
  logic [CNT_W-1:0]  w_rev_cnt;
  logic [CNT_W-1:0]  w_same_cnt;
  logic [CNT_W-1:0]  w_rev_next;
  logic [CNT_W-1:0]  w_same_next;

  // r_blank saturates at SETTLE_CYC; below that pd decisions are not trusted
  assign w_settled   = (r_blank == BLK_W'(SETTLE_CYC));
  assign w_take      = pd_valid && w_settled;
  assign w_rev_next  = w_reversal ? w_rev_cnt + CNT_W'(1) : '0;
  assign w_same_next = w_reversal ? '0 : w_same_cnt + CNT_W'(1);

  always_comb begin
    w_next      = r_state;
    w_restart   = 1'b0;
    w_load      = 1'b0;
    w_load_val  = code;
    w_step      = 1'b0;
    w_clr_cnt   = 1'b0;
    w_blank_clr = 1'b0;
    if (start) begin
      w_next      = ST_SETTLE;
      w_restart   = 1'b1;
      w_load      = 1'b1;
      w_load_val  = '0;
      w_load_val[CODE_W-1] = 1'b1;
      w_blank_clr = 1'b1;
    end else begin
      case (r_state)
        ST_SETTLE: if (r_blank == BLK_W'(SETTLE_CYC - 1)) w_next = ST_SAMPLE;
        ST_SAMPLE: begin
          if (pd_valid) begin
            w_load      = 1'b1;
            w_blank_clr = 1'b1;
            w_load_val[r_bit_idx] = pd_lead;
            if (r_bit_idx != '0) begin
              w_load_val[r_bit_idx - IDX_W'(1)] = 1'b1;
              w_next = ST_SETTLE;
            end else begin
              w_next = ST_TRACK;
            end
          end
        end
        ST_TRACK: begin
          if (w_take) begin
            w_step      = 1'b1;
            w_blank_clr = 1'b1;
            if (w_rev_next == CNT_W'(LOCK_CNT)) w_next = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_take) begin
            w_step      = 1'b1;
            w_blank_clr = 1'b1;
            if (w_same_next == CNT_W'(UNLOCK_CNT)) begin
              w_next    = ST_TRACK;
              w_clr_cnt = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_blank   <= '0;
      r_bit_idx <= '0;
      r_sel     <= SEL_GATE;
      r_locked  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_blank_clr)     r_blank <= '0;
      else if (!w_settled) r_blank <= r_blank + BLK_W'(1);
      if (start)
        r_bit_idx <= IDX_W'(CODE_W - 1);
      else if (r_state == ST_SAMPLE && pd_valid && r_bit_idx != '0)
        r_bit_idx <= r_bit_idx - IDX_W'(1);
      r_sel    <= sel_of(w_next);
      r_locked <= (w_next == ST_LOCKED);
      r_busy   <= (w_next == ST_SETTLE) || (w_next == ST_SAMPLE) || (w_next == ST_TRACK);
    end
  end

  dcdl_code_stepper #(
    .CODE_W (CODE_W),
    .CNT_W  (CNT_W)
  ) u_stepper (
    .clk_ext    (clk_ext),
    .rst_n      (rst_n),
    .i_restart  (w_restart),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_step     (w_step),
    .i_up       (pd_lead),
    .i_clr_cnt  (w_clr_cnt),
    .o_code     (code),
    .o_reversal (w_reversal),
    .o_rev_cnt  (w_rev_cnt),
    .o_same_cnt (w_same_cnt),
    .o_sat      (range_err)
  );

  assign sel    = r_sel;
  assign locked = r_locked;
  assign busy   = r_busy;

endmodule

// File: tb/tb_dcdl_lock_ctrl.sv
// tb/tb_dcdl_lock_ctrl.sv - directed self-checking bench for dcdl_lock_ctrl
module tb_dcdl_lock_ctrl;
  import fmdll_pkg::*;

  logic       clk_ext = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pd_valid;
  logic       pd_lead;
  logic [9:0] code;
  logic [1:0] sel;
  logic       locked;
  logic       busy;
  logic       range_err;

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  bit         pd_en = 0;
  bit         force_lead = 0;
  bit         sat_mode = 0;
  logic [9:0] prev_code = '0;
  logic [9:0] seen[$];

  dcdl_lock_ctrl u_dut (
    .clk_ext   (clk_ext),
    .rst_n     (rst_n),
    .start     (start),
    .pd_valid  (pd_valid),
    .pd_lead   (pd_lead),
    .code      (code),
    .sel       (sel),
    .locked    (locked),
    .busy      (busy),
    .range_err (range_err)
  );

  always #5 clk_ext = ~clk_ext;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one clock: inputs change 1 time unit after the edge, PD model answers for the settled code
  task automatic tick();
    @(posedge clk_ext);
    #1;
    cyc++;
    start = 1'b0;
    if (pd_en) begin
      pd_valid = cyc[0];
      pd_lead  = force_lead | sat_mode | (code < 10'd421);
    end else begin
      pd_valid = 1'b0;
      pd_lead  = 1'b0;
    end
    if (code != prev_code) begin
      seen.push_back(code);
      prev_code = code;
    end
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
  endtask

  task automatic collect(input string tag, input int n, input int budget);
    int k = 0;
    while (seen.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (seen.size() < n) check(tag, seen.size(), n);
  endtask

  logic [9:0] exp_acq [11] = '{10'd512, 10'd256, 10'd384, 10'd448, 10'd416, 10'd432,
                               10'd424, 10'd420, 10'd422, 10'd421, 10'd420};

  initial begin
    int bad;
    int k;
    rst_n    = 1'b0;
    start    = 1'b0;
    pd_valid = 1'b0;
    pd_lead  = 1'b0;

    #12;
    check("rst_code", code, 0);
    check("rst_sel", sel, SEL_GATE);
    check("rst_locked", locked, 0);
    check("rst_busy", busy, 0);
    check("rst_range_err", range_err, 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if (code !== 10'd0 || sel !== 2'b10 || locked !== 1'b0 || busy !== 1'b0 || range_err !== 1'b0)
        bad++;
    end
    check("idle_hold", bad, 0);

    // acquisition
    pd_en = 1;
    seen.delete();
    pulse_start();
    check("start_code", code, 512);
    check("start_sel", sel, SEL_INJECT);
    check("start_busy", busy, 1);
    collect("acq_timeout", 11, 400);
    for (int i = 0; i < 11; i++)
      if (i < seen.size()) check($sformatf("acq_code_%0d", i), seen[i], exp_acq[i]);
    check("acq_sel", sel, SEL_INJECT);
    check("acq_locked", locked, 0);

    // lock after 8 reversals (9 tracking steps)
    seen.delete();
    k = 0;
    while (!locked && k < 400) begin
      tick();
      k++;
    end
    check("lock_reached", locked, 1);
    check("lock_steps", seen.size(), 9);
    if (seen.size() >= 2) begin
      check("track_step0", seen[0], 421);
      check("track_step1", seen[1], 420);
    end
    check("lock_code", code, 421);
    check("lock_sel", sel, SEL_RECIRC);
    check("lock_busy", busy, 0);

    // unlock after 4 same-direction steps
    force_lead = 1;
    seen.delete();
    k = 0;
    while (locked && k < 200) begin
      tick();
      k++;
    end
    force_lead = 0;
    check("unlock_locked", locked, 0);
    check("unlock_steps", seen.size(), 4);
    check("unlock_code", code, 425);
    check("unlock_sel", sel, SEL_INJECT);
    check("unlock_busy", busy, 1);

    // saturation at max code
    sat_mode = 1;
    pulse_start();
    k = 0;
    while (code != 10'd1023 && k < 400) begin
      tick();
      k++;
    end
    check("sat_sar_code", code, 1023);
    check("sat_sar_rerr", range_err, 0);
    k = 0;
    while (!range_err && k < 200) begin
      tick();
      k++;
    end
    check("sat_rerr", range_err, 1);
    check("sat_code_hold", code, 1023);
    check("sat_locked", locked, 0);
    sat_mode = 0;
    pulse_start();
    check("sat_clear_rerr", range_err, 0);
    check("sat_clear_code", code, 512);

    // restart mid-acquisition
    tick();
    seen.delete();
    prev_code = code;
    pulse_start();
    seen.delete();
    collect("restart_timeout", 4, 200);
    if (seen.size() >= 4) check("pre_restart_code", seen[3], 416);
    seen.delete();
    pulse_start();
    check("restart_code", code, 512);
    collect("restart_seq_timeout", 2, 200);
    if (seen.size() >= 2) begin
      check("restart_seq0", seen[0], 512);
      check("restart_seq1", seen[1], 256);
    end

    // start and pd_valid in the same cycle while tracking
    repeat (150) tick();
    check("pre_collide_busy", busy | locked, 1);
    tick();
    start    = 1'b1;
    pd_valid = 1'b1;
    pd_lead  = 1'b1;
    tick();
    check("collide_code", code, 512);
    check("collide_locked", locked, 0);
    check("collide_sel", sel, SEL_INJECT);

    // asynchronous reset mid-operation
    repeat (30) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_code", code, 0);
    check("arst_sel", sel, SEL_GATE);
    check("arst_busy", busy, 0);
    check("arst_locked", locked, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
